// File: rtl/iob_l2_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_l2_req_arbiter_pkg
//  Description : Shared types and constants for the two-master native-IOb
//                L2 request arbiter: FSM state encoding and master IDs.
//  Contents    : arb_state_t  - arbiter FSM states (IDLE / LOCK / INV)
//                MST_I, MST_D - master IDs (instruction = 0, data = 1)
//                other_master - returns the master that is not the argument
//  Revision    : 1.0 - initial release
// ============================================================================
package iob_l2_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_INV  = 2'd2
    } arb_state_t;

    localparam logic MST_I = 1'b0;
    localparam logic MST_D = 1'b1;

    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_l2_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : iob_l2_req_arbiter_if
//  Description : Native-IOb bus bundle, N lanes wide (lane k occupies slice
//                k of every field). The masters' side of the arbiter uses
//                N=2, the L2 side uses N=1.
//  Signals     : avalid / addr / wdata / wstrb - request (master drives)
//                ready / rvalid / rdata         - response (slave drives)
//  Modports    : master - request issuer
//                slave  - request acceptor
//  Revision    : 1.0 - initial release
// ============================================================================
interface iob_l2_req_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) ();
    logic [N-1:0]            avalid;
    logic [N*ADDR_W-1:0]     addr;
    logic [N*DATA_W-1:0]     wdata;
    logic [N*(DATA_W/8)-1:0] wstrb;
    logic [N-1:0]            ready;
    logic [N-1:0]            rvalid;
    logic [N*DATA_W-1:0]     rdata;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/iob_l2_req_arbiter_rd_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : iob_rd_id_fifo
//  Description : Synchronous 1-bit wide FIFO, 2**DEPTH_W entries, holding the
//                master ID of every read accepted by the L2 so responses can
//                be routed back in issue order.
//  Ports       : clk, rst      - clock, synchronous active-high reset (flush)
//                push, din     - enqueue din
//                pop, dout     - dequeue; dout is the current head
//                full, empty   - occupancy flags
//                count         - number of stored entries
//  Notes       : push and pop in the same cycle are allowed, also when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_rd_id_fifo
    import iob_l2_req_arbiter_pkg::*;
#(
    parameter int DEPTH_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             din,
    input  wire logic             pop,
    output logic                  dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_W:0]      count
);
    localparam int               c_depth     = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0] c_depth_cnt = (DEPTH_W + 1)'(c_depth);

    logic                r_mem [c_depth];
    logic [DEPTH_W-1:0]  r_wptr;
    logic [DEPTH_W-1:0]  r_rptr;
    logic [DEPTH_W:0]    r_count;
    logic                w_do_push;
    logic                w_do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle; the write then lands in the slot being vacated.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_count == c_depth_cnt);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/iob_l2_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iob_l2_req_arbiter
//  Description : Shares one native-IOb L2 front-end between master 0
//                (instruction path) and master 1 (data path). Round-robin
//                grant with lock until accepted, in-order read response
//                routing, and invalidate sequencing that waits for an idle
//                bus with all reads drained.
//  Ports       : clk_i, cke_i, rst_i - clock, clock enable, sync reset
//                m_bus  (slave,  N=2) - the two requesters
//                s_bus  (master, N=1) - towards the L2 cache
//                inv_req_i            - invalidate request pulse
//                inv_o                - one-cycle invalidate strobe to L2
//                busy_o               - invalidate pending/issuing, LOCK, or
//                                       reads outstanding
//                err_o                - sticky: read data seen with no
//                                       outstanding read
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_l2_req_arbiter
    import iob_l2_req_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int OUTST_W = 2
) (
    input  wire logic             clk_i,
    input  wire logic             cke_i,
    input  wire logic             rst_i,
    iob_l2_req_arbiter_if.slave   m_bus,
    iob_l2_req_arbiter_if.master  s_bus,
    input  wire logic             inv_req_i,
    output logic                  inv_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    logic                r_owner;
    logic                r_prio;
    logic                r_inv_pend;
    logic                r_inv;
    logic                r_err;

    logic                w_run;
    logic                w_grant_vld;
    logic                w_grant_id;
    logic [1:0]          w_grant_oh;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [STRB_W-1:0]   w_sel_wstrb;
    logic                w_accept;
    logic                w_push;
    logic                w_rvalid;
    logic                w_pop;
    logic                w_orphan;
    logic                w_drained;

    logic                w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [OUTST_W:0]    w_fifo_count;

    // Combinational outputs are suppressed while in reset or clock-gated so
    // nothing is accepted that the state registers would fail to record.
    assign w_run = cke_i & ~rst_i;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = r_prio;
        if (w_run) begin
            if (r_state == ST_LOCK) begin
                w_grant_vld = 1'b1;
                w_grant_id  = r_owner;
            end else if (r_state == ST_IDLE && !r_inv_pend && !w_fifo_full) begin
                case (m_bus.avalid)
                    2'b11: begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = r_prio;
                    end
                    2'b01: begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = MST_I;
                    end
                    2'b10: begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = MST_D;
                    end
                    default: begin
                        w_grant_vld = 1'b0;
                        w_grant_id  = r_prio;
                    end
                endcase
            end
        end
    end

    assign w_grant_oh = !w_grant_vld ? 2'b00 :
                        (w_grant_id == MST_D) ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------
    // Request path: mux of the granted master, zero when nobody owns it
    // ------------------------------------------------------------------
    assign w_sel_addr  = (w_grant_id == MST_D) ? m_bus.addr[2*ADDR_W-1:ADDR_W]
                                               : m_bus.addr[ADDR_W-1:0];
    assign w_sel_wdata = (w_grant_id == MST_D) ? m_bus.wdata[2*DATA_W-1:DATA_W]
                                               : m_bus.wdata[DATA_W-1:0];
    assign w_sel_wstrb = (w_grant_id == MST_D) ? m_bus.wstrb[2*STRB_W-1:STRB_W]
                                               : m_bus.wstrb[STRB_W-1:0];

    assign s_bus.avalid = w_grant_vld;
    assign s_bus.addr   = w_grant_vld ? w_sel_addr  : '0;
    assign s_bus.wdata  = w_grant_vld ? w_sel_wdata : '0;
    assign s_bus.wstrb  = w_grant_vld ? w_sel_wstrb : '0;
    assign m_bus.ready  = w_grant_oh & {2{s_bus.ready[0]}};

    assign w_accept = w_grant_vld & s_bus.ready[0];
    assign w_push   = w_accept & (w_sel_wstrb == '0);

    // ------------------------------------------------------------------
    // Response path: head of the ID FIFO steers read data
    // ------------------------------------------------------------------
    assign w_rvalid = s_bus.rvalid[0] & w_run;
    assign w_pop    = w_rvalid & ~w_fifo_empty;
    assign w_orphan = w_rvalid & w_fifo_empty;

    assign m_bus.rvalid = !w_pop ? 2'b00 :
                          (w_fifo_head == MST_D) ? 2'b10 : 2'b01;
    assign m_bus.rdata  = {2{s_bus.rdata}};

    // The last outstanding read draining this cycle lets the invalidate
    // fire on the very next cycle. No push can coincide: a pending
    // invalidate blocks every grant in IDLE.
    assign w_drained = w_fifo_empty |
                       ((w_fifo_count == (OUTST_W + 1)'(1)) & w_pop & ~w_push);

    iob_rd_id_fifo #(
        .DEPTH_W (OUTST_W)
    ) u_rd_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_push),
        .din   (w_grant_id),
        .pop   (w_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // FSM, priority, invalidate and error state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= MST_I;
            r_prio     <= MST_I;
            r_inv_pend <= 1'b0;
            r_inv      <= 1'b0;
            r_err      <= 1'b0;
        end else if (cke_i) begin
            r_inv <= 1'b0;
            if (inv_req_i) r_inv_pend <= 1'b1;
            if (w_orphan)  r_err      <= 1'b1;
            if (w_accept)  r_prio     <= other_master(w_grant_id);

            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        if (!s_bus.ready[0]) begin
                            r_state <= ST_LOCK;
                            r_owner <= w_grant_id;
                        end
                    end else if (r_inv_pend && w_drained) begin
                        // Clearing here overrides a same-cycle inv_req_i,
                        // which therefore coalesces into this invalidate.
                        r_state    <= ST_INV;
                        r_inv      <= 1'b1;
                        r_inv_pend <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    if (w_accept) r_state <= ST_IDLE;
                end
                ST_INV: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign inv_o  = r_inv;
    assign err_o  = r_err;
    // The INV cycle itself still counts as invalidate activity.
    assign busy_o = r_inv_pend | (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_iob_l2_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_l2_req_arbiter
//  Description : Directed self-checking bench for iob_l2_req_arbiter
//                (ADDR_W=30, DATA_W=32, OUTST_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_l2_req_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic cke_i;
    logic rst_i;
    logic inv_req_i;
    logic inv_o;
    logic busy_o;
    logic err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    iob_l2_req_arbiter_if #(.N(2), .ADDR_W(AW), .DATA_W(DW)) m_bus ();
    iob_l2_req_arbiter_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) s_bus ();

    iob_l2_req_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .OUTST_W (2)
    ) dut (
        .clk_i     (clk_i),
        .cke_i     (cke_i),
        .rst_i     (rst_i),
        .m_bus     (m_bus),
        .s_bus     (s_bus),
        .inv_req_i (inv_req_i),
        .inv_o     (inv_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m(input int k, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
        m_bus.avalid[k]        = v;
        m_bus.addr[k*AW +: AW] = a;
        m_bus.wdata[k*DW +: DW] = d;
        m_bus.wstrb[k*4 +: 4]  = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        cke_i      = 1'b1;
        rst_i      = 1'b1;
        inv_req_i  = 1'b0;
        s_bus.ready  = 1'b1;
        s_bus.rvalid = 1'b0;
        s_bus.rdata  = '0;
        drive_m(0, 1'b1, 30'h100, 32'h0, 4'h0);
        drive_m(1, 1'b1, 30'h200, 32'h0, 4'h0);
        tick();
        tick();
        settle();
        chk("rst_s_avalid", s_bus.avalid, 1'b0);
        chk("rst_m_ready",  m_bus.ready,  2'b00);
        chk("rst_m_rvalid", m_bus.rvalid, 2'b00);
        chk("rst_inv",      inv_o,        1'b0);
        chk("rst_busy",     busy_o,       1'b0);
        chk("rst_err",      err_o,        1'b0);

        // ---------------- round robin, fill FIFO ----------------
        rst_i = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("alt_ready", m_bus.ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_addr",  s_bus.addr,  (i % 2 == 0) ? 30'h100 : 30'h200);
            tick();
            settle();
        end
        // four reads outstanding: no grant
        chk("full_s_avalid", s_bus.avalid, 1'b0);
        chk("full_m_ready",  m_bus.ready,  2'b00);
        chk("full_busy",     busy_o,       1'b1);
        tick();
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'hCAFE0001;
        settle();
        chk("rv0_route",  m_bus.rvalid, 2'b01);
        chk("rv0_rdata",  m_bus.rdata,  64'hCAFE0001_CAFE0001);
        chk("rv0_noreq",  s_bus.avalid, 1'b0);
        tick();
        s_bus.rvalid = 1'b0;
        settle();
        chk("slot_freed_ready", m_bus.ready, 2'b01);
        chk("slot_freed_addr",  s_bus.addr,  30'h100);
        tick();
        drive_m(0, 1'b0, 30'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 30'h0, 32'h0, 4'h0);
        s_bus.rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_route", m_bus.rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        s_bus.rvalid = 1'b0;
        settle();
        chk("drained_busy",   busy_o,       1'b0);
        chk("drained_rvalid", m_bus.rvalid, 2'b00);

        // ---------------- lock on m1 write ----------------
        tick();
        s_bus.ready = 1'b0;
        drive_m(1, 1'b1, 30'h300, 32'hDEADBEEF, 4'hF);
        settle();
        chk("lock_req_avalid", s_bus.avalid, 1'b1);
        chk("lock_req_addr",   s_bus.addr,   30'h300);
        chk("lock_req_ready",  m_bus.ready,  2'b00);
        tick();
        drive_m(0, 1'b1, 30'h111, 32'h0, 4'h0);
        settle();
        chk("lock_hold_addr",  s_bus.addr,  30'h300);
        chk("lock_hold_wdata", s_bus.wdata, 32'hDEADBEEF);
        chk("lock_hold_busy",  busy_o,      1'b1);
        tick();
        settle();
        chk("lock_hold2_addr", s_bus.addr, 30'h300);
        tick();
        s_bus.ready = 1'b1;
        settle();
        chk("lock_acc_ready", m_bus.ready, 2'b10);
        chk("lock_acc_wstrb", s_bus.wstrb, 4'hF);
        tick();
        drive_m(1, 1'b0, 30'h0, 32'h0, 4'h0);
        settle();
        chk("post_lock_ready", m_bus.ready, 2'b01);
        chk("post_lock_addr",  s_bus.addr,  30'h111);
        tick();
        drive_m(0, 1'b0, 30'h0, 32'h0, 4'h0);

        // ---------------- invalidate with reads outstanding ----------------
        drive_m(1, 1'b1, 30'h222, 32'h0, 4'h0);
        settle();
        chk("inv_pre_ready", m_bus.ready, 2'b10);
        tick();
        drive_m(1, 1'b0, 30'h0, 32'h0, 4'h0);
        drive_m(0, 1'b1, 30'h123, 32'h0, 4'h0);
        inv_req_i = 1'b1;
        settle();
        chk("inv_same_cycle_grant", m_bus.ready, 2'b01);
        tick();
        inv_req_i = 1'b0;
        drive_m(0, 1'b1, 30'h124, 32'h0, 4'h0);
        settle();
        chk("inv_block_avalid", s_bus.avalid, 1'b0);
        chk("inv_block_busy",   busy_o,       1'b1);
        tick();
        s_bus.rvalid = 1'b1;
        settle();
        chk("inv_rv1_route", m_bus.rvalid, 2'b01);
        tick();
        settle();
        chk("inv_rv2_route", m_bus.rvalid, 2'b10);
        tick();
        settle();
        chk("inv_rv3_route", m_bus.rvalid, 2'b01);
        chk("inv_rv3_noinv", inv_o,        1'b0);
        tick();
        s_bus.rvalid = 1'b0;
        inv_req_i    = 1'b1;
        settle();
        chk("inv_pulse1",        inv_o,        1'b1);
        chk("inv_pulse1_noreq",  s_bus.avalid, 1'b0);
        tick();
        inv_req_i = 1'b0;
        settle();
        chk("inv_gap",        inv_o,        1'b0);
        chk("inv_gap_noreq",  s_bus.avalid, 1'b0);
        tick();
        settle();
        chk("inv_pulse2", inv_o, 1'b1);
        tick();
        settle();
        chk("inv_done",       inv_o,       1'b0);
        chk("inv_done_ready", m_bus.ready, 2'b01);
        chk("inv_done_addr",  s_bus.addr,  30'h124);
        tick();
        drive_m(0, 1'b0, 30'h0, 32'h0, 4'h0);
        s_bus.rvalid = 1'b1;
        settle();
        chk("inv_done_rv", m_bus.rvalid, 2'b01);
        tick();

        // ---------------- orphan read data, sticky error, reset ----------------
        settle();
        chk("orphan_no_rvalid", m_bus.rvalid, 2'b00);
        chk("orphan_err_pre",   err_o,        1'b0);
        tick();
        s_bus.rvalid = 1'b0;
        settle();
        chk("orphan_err_set", err_o, 1'b1);
        tick();
        settle();
        chk("orphan_err_sticky", err_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        chk("rst2_err", err_o, 1'b0);
        drive_m(0, 1'b1, 30'h010, 32'h0, 4'h0);
        drive_m(1, 1'b1, 30'h020, 32'h0, 4'h0);
        settle();
        chk("rst2_prio_ready", m_bus.ready, 2'b01);
        chk("rst2_prio_addr",  s_bus.addr,  30'h010);
        tick();
        drive_m(0, 1'b0, 30'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 30'h0, 32'h0, 4'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
